// File: rtl/allocator_islip.sv
// Iterative separable input-first (iSLIP-style) allocator with persistent round-robin grant/accept pointers.
// Optional feature: ALLOC_EARLY_EXIT_EN ends the iteration phase once no progress is possible.
module allocator_islip #(
    parameter int NUM_REQS  = 4,
    parameter int NUM_RESS  = 3,
    parameter int NUM_ITERS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_REQS*NUM_RESS-1:0] requests,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_RESS*NUM_REQS-1:0] grants,
    output logic [1:0]                   state_o
);
    localparam int GW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int AW = (NUM_RESS > 1) ? $clog2(NUM_RESS) : 1;
    localparam int IW = $clog2(NUM_ITERS + 1);
    localparam int NB = NUM_REQS * NUM_RESS;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd2} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  iter_q, iter_d;
    // req_q uses the input layout (i*NUM_RESS+j); match/grant vectors use j*NUM_REQS+i.
    logic [NB-1:0]  req_q, match_q, grants_q;
    logic [GW-1:0]  g_ptr_q [NUM_RESS];
    logic [GW-1:0]  g_ptr_d [NUM_RESS];
    logic [AW-1:0]  a_ptr_q [NUM_REQS];
    logic [AW-1:0]  a_ptr_d [NUM_REQS];
    logic [NUM_REQS-1:0] req_free;
    logic [NUM_RESS-1:0] res_free;
    logic [NB-1:0]  elig, gnt, acc, match_d;
    logic           last_iter;
    int             best;

    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx + n - ptr) % n;
    endfunction

    always_comb begin
        req_free = '1;
        res_free = '1;
        elig     = '0;
        gnt      = '0;
        acc      = '0;
        best     = 0;
        for (int j = 0; j < NUM_RESS; j++)
            for (int i = 0; i < NUM_REQS; i++)
                if (match_q[j*NUM_REQS+i]) begin
                    req_free[i] = 1'b0;
                    res_free[j] = 1'b0;
                end
        for (int j = 0; j < NUM_RESS; j++)
            for (int i = 0; i < NUM_REQS; i++)
                elig[j*NUM_REQS+i] = req_q[i*NUM_RESS+j] & req_free[i] & res_free[j];
        // Grant: each resource takes the eligible requester closest at/after its pointer.
        for (int j = 0; j < NUM_RESS; j++) begin
            best = NUM_REQS;
            for (int i = 0; i < NUM_REQS; i++)
                if (elig[j*NUM_REQS+i] && rr_dist(i, int'(g_ptr_q[j]), NUM_REQS) < best)
                    best = rr_dist(i, int'(g_ptr_q[j]), NUM_REQS);
            for (int i = 0; i < NUM_REQS; i++)
                if (elig[j*NUM_REQS+i] && rr_dist(i, int'(g_ptr_q[j]), NUM_REQS) == best)
                    gnt[j*NUM_REQS+i] = 1'b1;
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            best = NUM_RESS;
            for (int j = 0; j < NUM_RESS; j++)
                if (gnt[j*NUM_REQS+i] && rr_dist(j, int'(a_ptr_q[i]), NUM_RESS) < best)
                    best = rr_dist(j, int'(a_ptr_q[i]), NUM_RESS);
            for (int j = 0; j < NUM_RESS; j++)
                if (gnt[j*NUM_REQS+i] && rr_dist(j, int'(a_ptr_q[i]), NUM_RESS) == best)
                    acc[j*NUM_REQS+i] = 1'b1;
        end
        match_d = match_q | acc;
    end

    always_comb begin
        g_ptr_d = g_ptr_q;
        a_ptr_d = a_ptr_q;
        if (state_q == S_ITER && iter_q == IW'(1))
            for (int j = 0; j < NUM_RESS; j++)
                for (int i = 0; i < NUM_REQS; i++)
                    if (acc[j*NUM_REQS+i]) begin
                        g_ptr_d[j] = GW'((i + 1) % NUM_REQS);
                        a_ptr_d[i] = AW'((j + 1) % NUM_RESS);
                    end
    end

`ifdef ALLOC_EARLY_EXIT_EN
    logic any_elig_d;
    always_comb begin
        any_elig_d = 1'b0;
        for (int j = 0; j < NUM_RESS; j++)
            for (int i = 0; i < NUM_REQS; i++)
                if (req_q[i*NUM_RESS+j]) begin
                    logic hit;
                    hit = 1'b0;
                    for (int k = 0; k < NUM_REQS; k++)
                        if (match_d[j*NUM_REQS+k]) hit = 1'b1;
                    for (int k = 0; k < NUM_RESS; k++)
                        if (match_d[k*NUM_REQS+i]) hit = 1'b1;
                    if (!hit) any_elig_d = 1'b1;
                end
        last_iter = (iter_q == IW'(NUM_ITERS)) || (acc == '0) || !any_elig_d;
    end
`else
    always_comb last_iter = (iter_q == IW'(NUM_ITERS));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ITER;
                iter_d  = IW'(1);
            end
            S_ITER: begin
                if (last_iter) state_d = S_DONE;
                else           iter_d  = iter_q + IW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        grants  = grants_q;
        state_o = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_q   <= '0;
            req_q    <= '0;
            match_q  <= '0;
            grants_q <= '0;
            for (int j = 0; j < NUM_RESS; j++) g_ptr_q[j] <= '0;
            for (int i = 0; i < NUM_REQS; i++) a_ptr_q[i] <= '0;
        end else begin
            iter_q  <= iter_d;
            g_ptr_q <= g_ptr_d;
            a_ptr_q <= a_ptr_d;
            if (state_q == S_IDLE && start) begin
                req_q   <= requests;
                match_q <= '0;
            end
            if (state_q == S_ITER) begin
                match_q <= match_d;
                if (last_iter) grants_q <= match_d;
            end
        end
    end
endmodule

// File: tb/tb_allocator_islip.sv
// Directed bench for allocator_islip: vector table of allocations plus hand sequences for reset and ignored starts.
module tb_allocator_islip;
    localparam int NB = 12;
`ifdef ALLOC_EARLY_EXIT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] requests;
    logic          busy, done;
    logic [NB-1:0] grants;
    logic [1:0]    state_o;

    int tests = 0;
    int fails = 0;
    logic [NB-1:0] exp_q[$];

    typedef struct {
        logic [NB-1:0] req;
        logic [NB-1:0] exp_g;
        int            exp_lat;
    } vec_t;
    vec_t vecs[6];

    allocator_islip #(.NUM_REQS(4), .NUM_RESS(3), .NUM_ITERS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .requests(requests),
        .busy(busy), .done(done), .grants(grants), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] mk_req(input logic [2:0] r0, input logic [2:0] r1,
                                             input logic [2:0] r2, input logic [2:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [NB-1:0] mk_g(input logic [3:0] g0, input logic [3:0] g1,
                                           input logic [3:0] g2);
        return {g2, g1, g0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the done cycle (lat=0 on timeout).
    task automatic run_alloc(input logic [NB-1:0] req, output logic [NB-1:0] g, output int lat);
        requests = req;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        g     = '0;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c;
                g   = grants;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b1;
        requests = '1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_grants", grants, '0);
        repeat (3) @(negedge clk);
        check("rst_hold_busy", busy, 1'b0);
        check("rst_hold_state", state_o, 2'd0);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("rst_after_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] g;
        int lat, pulses, done_cyc;
        logic [NB-1:0] done_g;

        vecs[0] = '{mk_req(3'b111, 3'b111, 3'b111, 3'b111), mk_g(4'b0001, 4'b0010, 4'b0000), 3};
        vecs[1] = '{mk_req(3'b111, 3'b111, 3'b111, 3'b111), mk_g(4'b0010, 4'b0001, 4'b0100), 3};
        vecs[2] = '{mk_req(3'b111, 3'b111, 3'b111, 3'b111), mk_g(4'b0100, 4'b0010, 4'b0001), SHORT_LAT};
        vecs[3] = '{mk_req(3'b000, 3'b000, 3'b000, 3'b000), mk_g(4'b0000, 4'b0000, 4'b0000), SHORT_LAT};
        vecs[4] = '{mk_req(3'b001, 3'b000, 3'b000, 3'b111), mk_g(4'b1000, 4'b0000, 4'b0000), SHORT_LAT};
        vecs[5] = '{mk_req(3'b000, 3'b110, 3'b010, 3'b100), mk_g(4'b0000, 4'b0100, 4'b0010), SHORT_LAT};

        reset = 1'b0; start = 1'b0; requests = '0;
        @(negedge clk);
        do_reset();

        // Back-to-back allocations: expected values depend on pointer state carried between vectors.
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].exp_g);
            run_alloc(vecs[v].req, g, lat);
            check($sformatf("v%0d_grants", v), g, exp_q.pop_front());
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", v), done, 1'b0);
            check($sformatf("v%0d_idle", v), busy, 1'b0);
            check($sformatf("v%0d_hold", v), grants, vecs[v].exp_g);
        end

        do_reset();
        run_alloc(mk_req(3'b001, 3'b000, 3'b000, 3'b000), g, lat);
        check("single_grants", g, mk_g(4'b0001, 4'b0000, 4'b0000));
        check("single_latency", lat, SHORT_LAT);
        @(negedge clk);
        run_alloc('0, g, lat);
        check("zero_grants", g, '0);
        check("zero_latency", lat, SHORT_LAT);
        @(negedge clk);

        // Starts in cycles 1 and 3 plus a request change in cycle 1 must not disturb the allocation.
        do_reset();
        requests = mk_req(3'b111, 3'b111, 3'b111, 3'b111);
        start    = 1'b1;
        pulses = 0; done_cyc = 0; done_g = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                done_cyc = c;
                done_g   = grants;
            end
            start = (c == 1 || c == 3);
            if (c == 1) requests = '0;
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_done_cycle", done_cyc, 3);
        check("ignore_grants", done_g, mk_g(4'b0001, 4'b0010, 4'b0000));
        check("ignore_idle", busy, 1'b0);

        // Reset in cycle 1 of an allocation discards it; pointers return to zero.
        requests = mk_req(3'b111, 3'b111, 3'b111, 3'b111);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midrst_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_grants", grants, '0);
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_alloc(mk_req(3'b111, 3'b111, 3'b111, 3'b111), g, lat);
        check("midrst_rerun_grants", g, mk_g(4'b0001, 4'b0010, 4'b0000));
        check("midrst_rerun_latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
